axi4_w_buf_slice: RTL
=====================

# axi4_w_buf_slice

Parametrised AXI4 write-data (W) channel buffer: a DEPTH-entry FIFO between a W-channel source and sink, with full throughput and no combinational path between the two sides. It generalises the single-stage W register slice to arbitrary depth, reports fill level and buffered-burst count, and can hold each burst until its WLAST beat has arrived (store-and-forward). It sits on W paths at clock-domain-free pipeline boundaries, typically ahead of memory-controller or crossbar ports that must not see W bubbles mid-burst.

## Interface
- DATA_WIDTH, 32, W data width in bits (multiple of 8)
- USER_WIDTH, 1, WUSER width (>=1)
- STRB_WIDTH, DATA_WIDTH/8, WSTRB width
- DEPTH, 4, FIFO entries; power of two, >=2
- CNT_WIDTH, $clog2(DEPTH)+1, width of status counters (derived, not overridden)

- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- wvalids / wreadys  in / out  1 / 1  source-side handshake
- wdatas, wstrbs, wlasts, wusers  in  DATA_WIDTH, STRB_WIDTH, 1, USER_WIDTH  source payload
- wvalidm / wreadym  out / in  1 / 1  sink-side handshake
- wdatam, wstrbm, wlastm, wuserm  out  DATA_WIDTH, STRB_WIDTH, 1, USER_WIDTH  sink payload
- fill_level  out  CNT_WIDTH  beats currently stored (0..DEPTH)
- burst_cnt  out  CNT_WIDTH  stored beats with WLAST=1 (0..DEPTH)

## Operation
- Payload stored as one word {wdata, wstrb, wlast, wuser}; order preserved exactly.
- Push when wvalids && wreadys; pop when wvalidm && wreadym.
- wreadys = (fill_level != DEPTH), driven from a flop (registered full flag); never depends on wreadym.
- wvalidm = head-eligible, driven from flops; never depends on wvalids.
- Cut-through (default): head eligible whenever fill_level != 0.
- Write pointer, read pointer: log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
- fill_level: +1 on push only, -1 on pop only, unchanged on push+pop.
- burst_cnt: +1 on push with wlasts=1, -1 on pop with wlastm=1, unchanged when both.
- Empty with push+pop not possible same cycle (wvalidm low when empty); no bypass path.
- Full: wreadys low; a simultaneous pop frees the slot, wreadys high next cycle.
- AXI rule honoured: once wvalidm high, it and the payload stay stable until popped.
- Source violations (wvalids dropping without handshake) are tolerated: nothing is pushed.
- Reset (any time, including mid-burst): pointers, fill_level, burst_cnt cleared; stored data discarded; wvalidm=0, wreadys=0 while aresetn low, wreadys=1 first edge after release. Payload outputs: 0 at reset (storage array need not be reset; output mux shows entry 0 reset to 0).

## Timing
- Latency: beat pushed at edge N visible on wvalidm after edge N (one cycle), cut-through mode.
- Throughput: one beat per cycle sustained in both directions at any fill level below DEPTH.
- Minimum DEPTH=2 keeps full throughput with registered wreadys.
- No combinational paths input-to-output on either handshake.

## Configuration
- Macro AXI4_W_BUF_STORE_FWD_EN.
- Defined: head eligible only when burst_cnt != 0 (a complete burst is buffered) OR fill_level == DEPTH (forced release; prevents deadlock for bursts longer than DEPTH, those pass in cut-through fashion). Once a burst's first beat is popped, eligibility continues until its WLAST pops, as long as beats are present.
- Undefined: pure cut-through; burst_cnt still reported.

## Test plan
- Single beat, DEPTH=4: wvalids=1, wdatas=0xA5A5A5A5, wlasts=1, wreadym=1 -> wvalidm=1 one cycle later with same payload; fill_level 1 then 0; burst_cnt 1 then 0.
- Back-to-back 16 beats, wreadym=1 throughout -> wreadys never drops, 16 beats out in order with one-cycle latency, fill_level stays at 1.
- Backpressure: wreadym=0, push 4 beats -> fill_level=4, wreadys=0 the cycle after 4th push; wreadym=1 for one cycle with wvalids=1 -> pop and no push that cycle, wreadys=1 next cycle, fill_level 3 then 4 after next push.
- Pointer wrap: DEPTH=4, alternating stall patterns over 23 beats with counting data 0..22 -> output sequence 0..22 exact, burst_cnt matches wlast beats buffered every cycle.
- Reset mid-burst: 3 beats stored, assert aresetn=0 asynchronously mid-cycle -> wvalidm, fill_level, burst_cnt =0 immediately; after release wreadys=1, next pushed beat emerges first.
- With AXI4_W_BUF_STORE_FWD_EN, DEPTH=8: push 4-beat burst one beat every 2 cycles -> wvalidm stays 0 until the cycle after the WLAST push, then 4 beats consecutive; 10-beat burst with wreadym=1 -> release begins once fill_level=8.

Source files
------------

// File: rtl/axi4_w_buf_slice.sv
// axi4_w_buf_slice: DEPTH-entry AXI4 W-channel FIFO, registered handshakes.
// Define AXI4_W_BUF_STORE_FWD_EN to hold each burst until WLAST is buffered.
module axi4_w_buf_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int DEPTH      = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    wvalids,
  output logic                    wreadys,
  input  logic [DATA_WIDTH-1:0]   wdatas,
  input  logic [STRB_WIDTH-1:0]   wstrbs,
  input  logic                    wlasts,
  input  logic [USER_WIDTH-1:0]   wusers,
  output logic                    wvalidm,
  input  logic                    wreadym,
  output logic [DATA_WIDTH-1:0]   wdatam,
  output logic [STRB_WIDTH-1:0]   wstrbm,
  output logic                    wlastm,
  output logic [USER_WIDTH-1:0]   wuserm,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [$clog2(DEPTH):0]  burst_cnt
);

  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int WW = DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [WW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] fill_q, fill_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic                 rdy_q, rdy_d;
  logic                 vld_q, vld_d;
  logic                 inb_q, inb_d;
  logic                 push, pop;
  logic [WW-1:0]        in_word;

  assign in_word = {wdatas, wstrbs, wlasts, wusers};
  assign {wdatam, wstrbm, wlastm, wuserm} = mem_q[rd_ptr_q];

  assign wreadys    = rdy_q;
  assign wvalidm    = vld_q;
  assign fill_level = fill_q;
  assign burst_cnt  = burst_q;

  always_comb begin
    push     = wvalids && rdy_q;
    pop      = vld_q && wreadym;
    wr_ptr_d = push ? wr_ptr_q + PONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PONE : rd_ptr_q;

    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase

    burst_d = burst_q;
    case ({push && wlasts, pop && wlastm})
      2'b10:   burst_d = burst_q + ONE;
      2'b01:   burst_d = burst_q - ONE;
      default: burst_d = burst_q;
    endcase

    // a burst whose head has left keeps flowing until its WLAST leaves
    inb_d = pop ? !wlastm : inb_q;
    rdy_d = (fill_d != FULL);
`ifdef AXI4_W_BUF_STORE_FWD_EN
    vld_d = (burst_d != '0) || (fill_d == FULL) ||
            (inb_d && (fill_d != '0));
`else
    vld_d = (fill_d != '0);
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      burst_q  <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      inb_q    <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_word;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      burst_q  <= burst_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      inb_q    <= inb_d;
    end
  end

endmodule
